// File: rtl/counter_pkg.sv
// Shared definitions for the counter sequencer: FSM state encoding, default
// parameter values and the command priority encoder.
package counter_pkg;

    // STATE output encoding is exposed on the STATE port, so values are fixed.
    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StClear = 2'b10,
        StLoad  = 2'b11
    } state_e;

    // Winning command after priority resolution. DIR is not in this set
    // because it never loses: it is applied alongside whatever wins.
    typedef enum logic [1:0] {
        CmdNone = 2'b00,
        CmdClr  = 2'b01,
        CmdLoad = 2'b10,
        CmdRun  = 2'b11
    } cmd_e;

    localparam int unsigned MODULUS_DEF  = 100;
    localparam int unsigned PRESCALE_DEF = 10;
    localparam int unsigned SYNC_STG_DEF = 2;

    // Command priority ranks, highest first. DIR ranks last but is never dropped.
    localparam int unsigned PRIO_CLR  = 0;
    localparam int unsigned PRIO_LOAD = 1;
    localparam int unsigned PRIO_RUN  = 2;
    localparam int unsigned PRIO_DIR  = 3;

    // Priority encoder: CLR > LOAD > RUN.
    function automatic cmd_e pick_cmd(input logic clr, input logic load, input logic run);
        cmd_e c;
        if (clr) begin
            c = CmdClr;
        end else if (load) begin
            c = CmdLoad;
        end else if (run) begin
            c = CmdRun;
        end else begin
            c = CmdNone;
        end
        return c;
    endfunction

    // Out-of-range preset values clamp to the top terminal count.
    function automatic logic [7:0] sat_load(input logic [7:0] v, input int unsigned modulus);
        logic [7:0] r;
        if ({24'd0, v} >= modulus) begin
            r = 8'(modulus - 1);
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_pulse.sv
// Pushbutton conditioner: SYNC_STG-flop synchroniser followed by a registered
// rising-edge detector. A held button yields a single one-cycle pulse.
// Latency from the raw edge to the pulse is SYNC_STG+1 cycles.
// Ports:
//   CLK   clock
//   RST   asynchronous active-high reset
//   btn   raw, asynchronous button level
//   pulse one-cycle command pulse
module btn_pulse #(
    parameter int unsigned SYNC_STG = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic btn,
    output logic pulse
);

    logic [SYNC_STG-1:0] sync_q;
    logic                prev_q;
    logic                pulse_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STG-2:0], btn};
            prev_q  <= sync_q[SYNC_STG-1];
            pulse_q <= sync_q[SYNC_STG-1] & ~prev_q;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/counter_sequencer.sv
// Control front-end for the mod-MODULUS up/down counter. Conditions the four
// pushbuttons into one-cycle commands, resolves their priority, runs the
// IDLE/RUN/CLEAR/LOAD state machine, prescales the clock into count-enable
// ticks and flags ticks that wrap the counter.
// Ports:
//   CLK, RST      clock, asynchronous active-high reset
//   BTN_RUN       raw button: toggle run/stop
//   BTN_DIR       raw button: toggle count direction
//   BTN_CLR       raw button: clear counter
//   BTN_LOAD      raw button: load LOAD_VAL into counter
//   LOAD_VAL      preset value, sampled when the LOAD command is taken
//   Q             counter value fed back from the counter
//   CNT_EN        one-cycle count enable to the counter
//   CNT_DIR       count direction, 1 = up
//   CNT_CLR       one-cycle synchronous clear to the counter
//   CNT_LOAD      one-cycle synchronous load to the counter
//   CNT_LOAD_VAL  value to load, valid while CNT_LOAD is high
//   WRAP          high with a CNT_EN that takes the count past a terminal value
//   STATE         current FSM state (00 IDLE, 01 RUN, 10 CLEAR, 11 LOAD)
module counter_sequencer
    import counter_pkg::*;
#(
    parameter int unsigned PRESCALE = PRESCALE_DEF,
    parameter int unsigned MODULUS  = MODULUS_DEF,
    parameter int unsigned SYNC_STG = SYNC_STG_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN_RUN,
    input  logic       BTN_DIR,
    input  logic       BTN_CLR,
    input  logic       BTN_LOAD,
    input  logic [7:0] LOAD_VAL,
    input  logic [7:0] Q,
    output logic       CNT_EN,
    output logic       CNT_DIR,
    output logic       CNT_CLR,
    output logic       CNT_LOAD,
    output logic [7:0] CNT_LOAD_VAL,
    output logic       WRAP,
    output logic [1:0] STATE
);

    localparam int unsigned PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [7:0]    Q_TOP      = 8'(MODULUS - 1);

    // Button conditioning
    logic cmd_run;
    logic cmd_dir;
    logic cmd_clr;
    logic cmd_load;

    btn_pulse #(.SYNC_STG(SYNC_STG)) u_btn_run (
        .CLK   (CLK),
        .RST   (RST),
        .btn   (BTN_RUN),
        .pulse (cmd_run)
    );

    btn_pulse #(.SYNC_STG(SYNC_STG)) u_btn_dir (
        .CLK   (CLK),
        .RST   (RST),
        .btn   (BTN_DIR),
        .pulse (cmd_dir)
    );

    btn_pulse #(.SYNC_STG(SYNC_STG)) u_btn_clr (
        .CLK   (CLK),
        .RST   (RST),
        .btn   (BTN_CLR),
        .pulse (cmd_clr)
    );

    btn_pulse #(.SYNC_STG(SYNC_STG)) u_btn_load (
        .CLK   (CLK),
        .RST   (RST),
        .btn   (BTN_LOAD),
        .pulse (cmd_load)
    );

    // Priority resolution
    cmd_e cmd;

    always_comb begin
        cmd = pick_cmd(cmd_clr, cmd_load, cmd_run);
    end

    // FSM, prescaler and registered command outputs
    state_e        state_q;
    logic          run_flag_q;   // CLEAR/LOAD was entered from RUN
    logic          dir_q;
    logic [PW-1:0] presc_q;
    logic          clr_q;
    logic          load_q;
    logic [7:0]    load_val_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StIdle;
            run_flag_q <= 1'b0;
            dir_q      <= 1'b1;
            presc_q    <= '0;
            clr_q      <= 1'b0;
            load_q     <= 1'b0;
            load_val_q <= '0;
        end else begin
            clr_q  <= 1'b0;
            load_q <= 1'b0;

            // DIR never competes; a tick in this cycle still sees the old value.
            if (cmd_dir) begin
                dir_q <= ~dir_q;
            end

            unique case (state_q)
                StIdle, StRun: begin
                    unique case (cmd)
                        CmdClr: begin
                            state_q    <= StClear;
                            run_flag_q <= (state_q == StRun);
                            clr_q      <= 1'b1;
                            presc_q    <= '0;
                        end
                        CmdLoad: begin
                            state_q    <= StLoad;
                            run_flag_q <= (state_q == StRun);
                            load_q     <= 1'b1;
                            load_val_q <= sat_load(LOAD_VAL, MODULUS);
                            presc_q    <= '0;
                        end
                        CmdRun: begin
                            state_q <= (state_q == StRun) ? StIdle : StRun;
                            // Zeroed so the first tick after entering RUN is a full period away.
                            presc_q <= '0;
                        end
                        CmdNone: begin
                            if (state_q == StRun) begin
                                presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
                            end
                        end
                    endcase
                end
                StClear, StLoad: begin
                    state_q <= run_flag_q ? StRun : StIdle;
                    presc_q <= '0;
                end
            endcase
        end
    end

    // Outputs
    assign CNT_EN       = (state_q == StRun) && (presc_q == PRESC_LAST);
    assign CNT_DIR      = dir_q;
    assign CNT_CLR      = clr_q;
    assign CNT_LOAD     = load_q;
    assign CNT_LOAD_VAL = load_val_q;
    assign STATE        = state_q;

    // Q is still the pre-tick value while CNT_EN is high.
    assign WRAP = CNT_EN & ((dir_q & (Q == Q_TOP)) | (~dir_q & (Q == 8'd0)));

endmodule
